// File: rtl/vote_tally_reader.sv
// vote_tally_reader: reader end of the vote machine display interface.
// Closes the poll, steps the Result strobe once per candidate, samples the
// display into a tally file, and tracks winner / tie / grand total.
// Optional build macro VOTE_READER_CHECK_EN adds one extra step that reads the
// machine's own total display and flags a disagreement on err_mismatch.
//
// Handshake: start is a single-cycle request, accepted only in IDLE or DONE
// (busy=0); a start seen while busy=1 is dropped, never queued. done stays high
// until the next accepted start or reset.
module vote_tally_reader #(
    parameter int NUM_CAND   = 16,
    parameter int CNT_W      = 12,
    parameter int PULSE_CYC  = 2,
    parameter int SETTLE_CYC = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               close_o,
    output logic               result_o,
    input  logic [CNT_W-1:0]   disp_i,
    input  logic [3:0]         rd_idx,
    output logic [CNT_W-1:0]   rd_data,
    output logic [3:0]         winner,
    output logic [CNT_W-1:0]   winner_cnt,
    output logic               tie,
    output logic [CNT_W+3:0]   total,
`ifdef VOTE_READER_CHECK_EN
    output logic               err_mismatch,
`endif
    output logic [2:0]         dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLOSE   = 3'd1,
        S_SETTLE0 = 3'd2,
        S_PULSE   = 3'd3,
        S_WAIT    = 3'd4,
        S_SAMPLE  = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    // Index of the final SAMPLE step; the check step reads one slot past the candidates.
`ifdef VOTE_READER_CHECK_EN
    localparam logic [4:0] LAST_IDX = 5'(NUM_CAND);
`else
    localparam logic [4:0] LAST_IDX = 5'(NUM_CAND - 1);
`endif

    state_t              state_q, state_d;
    logic [15:0]         cnt_q, cnt_d;
    logic [4:0]          idx_q, idx_d;
    logic [CNT_W-1:0]    tally_q [NUM_CAND];
    logic [CNT_W-1:0]    tally_d [NUM_CAND];
    logic [CNT_W-1:0]    rd_data_q, rd_data_d;
    logic [3:0]          winner_q, winner_d;
    logic [CNT_W-1:0]    winner_cnt_q, winner_cnt_d;
    logic                tie_q, tie_d;
    logic [CNT_W+3:0]    total_q, total_d;
    logic                err_q, err_d;
    logic                accept;

    assign accept = ((state_q == S_IDLE) || (state_q == S_DONE)) && start;

    // State register plus all datapath flops, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            rd_data_q    <= '0;
            winner_q     <= '0;
            winner_cnt_q <= '0;
            tie_q        <= 1'b0;
            total_q      <= '0;
            err_q        <= 1'b0;
            for (int k = 0; k < NUM_CAND; k++) tally_q[k] <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            rd_data_q    <= rd_data_d;
            winner_q     <= winner_d;
            winner_cnt_q <= winner_cnt_d;
            tie_q        <= tie_d;
            total_q      <= total_d;
            err_q        <= err_d;
            for (int k = 0; k < NUM_CAND; k++) tally_q[k] <= tally_d[k];
        end
    end

    // Next-state: close, settle, then PULSE/WAIT/SAMPLE per candidate.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_CLOSE;
                    cnt_d   = '0;
                end
            end
            S_CLOSE: begin
                state_d = S_SETTLE0;
                cnt_d   = '0;
            end
            S_SETTLE0: begin
                if (cnt_q == 16'(SETTLE_CYC - 1)) begin
                    state_d = S_PULSE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_PULSE: begin
                if (cnt_q == 16'(PULSE_CYC - 1)) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_WAIT: begin
                if (cnt_q == 16'(SETTLE_CYC - 1)) begin
                    state_d = S_SAMPLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_SAMPLE: begin
                if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_PULSE;
                    idx_d   = idx_q + 5'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath: clear on acceptance, capture/accumulate on SAMPLE, read port mux.
    always_comb begin
        for (int k = 0; k < NUM_CAND; k++) tally_d[k] = tally_q[k];
        winner_d     = winner_q;
        winner_cnt_d = winner_cnt_q;
        tie_d        = tie_q;
        total_d      = total_q;
        err_d        = err_q;
        if (accept) begin
            for (int k = 0; k < NUM_CAND; k++) tally_d[k] = '0;
            winner_d     = '0;
            winner_cnt_d = '0;
            tie_d        = 1'b0;
            total_d      = '0;
            err_d        = 1'b0;
        end else if (state_q == S_SAMPLE) begin
            if (idx_q < 5'(NUM_CAND)) begin
                for (int k = 0; k < NUM_CAND; k++) begin
                    if (idx_q == 5'(k)) tally_d[k] = disp_i;
                end
                total_d = total_q + (CNT_W + 4)'(disp_i);
                // First candidate seeds the running max; strict '>' keeps the lowest index on ties.
                if (idx_q == 5'd0 || disp_i > winner_cnt_q) begin
                    winner_d     = idx_q[3:0];
                    winner_cnt_d = disp_i;
                    tie_d        = 1'b0;
                end else if (disp_i == winner_cnt_q) begin
                    tie_d = 1'b1;
                end
            end
`ifdef VOTE_READER_CHECK_EN
            else begin
                err_d = (disp_i != total_q[CNT_W-1:0]);
            end
`endif
        end
        rd_data_d = '0;
        for (int k = 0; k < NUM_CAND; k++) begin
            if (rd_idx == 4'(k)) rd_data_d = tally_q[k];
        end
    end

    // Outputs decoded from the registered state so reset drops strobes on the same edge.
    always_comb begin
        busy     = (state_q != S_IDLE) && (state_q != S_DONE);
        done     = (state_q == S_DONE);
        close_o  = (state_q == S_CLOSE);
        result_o = (state_q == S_PULSE);
        dbg_state = state_q;
    end

    assign rd_data    = rd_data_q;
    assign winner     = winner_q;
    assign winner_cnt = winner_cnt_q;
    assign tie        = tie_q;
    assign total      = total_q;
`ifdef VOTE_READER_CHECK_EN
    assign err_mismatch = err_q;
`else
    logic unused_err;
    assign unused_err = err_q;
`endif

endmodule

// File: doc/vote_tally_reader.md
Name: vote_tally_reader

Overview:
- Read-out controller for the vote machine: the reader end of its display interface.
- On a start request it closes the poll, then steps the machine's Result control once per candidate.
- After each step it samples the 12-bit display and stores the count in an internal tally file.
- Computes winner, tie and grand total, and exposes the tally file through a random-access read port for the front panel / host.

Parameters:
- NUM_CAND, 16, number of candidates read out, 2..16.
- CNT_W, 12, width of the display value and of each stored tally.
- PULSE_CYC, 2, cycles result_o is held high per step, ≥1.
- SETTLE_CYC, 4, cycles waited after close_o and after each result_o fall before sampling, ≥1.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- start  in  1  one-cycle request to begin a read-out
- busy  out  1  high from start acceptance until done
- done  out  1  high while results are valid; held until the next accepted start or reset
- close_o  out  1  Close strobe to the vote machine
- result_o  out  1  Result strobe to the vote machine
- disp_i  in  CNT_W  display value from the vote machine
- rd_idx  in  4  tally file read address
- rd_data  out  CNT_W  tally[rd_idx], registered, 1-cycle latency; 0 if rd_idx ≥ NUM_CAND
- winner  out  4  index of the highest count
- winner_cnt  out  CNT_W  count of the winner
- tie  out  1  another candidate equals winner_cnt
- total  out  CNT_W+4  sum of all tallies

Behaviour:
- Reset (rst_n=0 at an edge):
  - State goes to IDLE.
  - All outputs go to 0 and the tally file clears.
  - Applies mid-operation: strobes drop on that same edge, and no partial results are kept.
- States: IDLE, CLOSE, SETTLE0, PULSE, WAIT, SAMPLE, DONE.
- IDLE:
  - start=1 → CLOSE.
  - busy=1 and done=0 from the next cycle.
  - winner, winner_cnt, tie, total and the tally file clear.
- CLOSE: close_o=1 for exactly 1 cycle → SETTLE0.
- SETTLE0: wait SETTLE_CYC cycles, index i=0 → PULSE.
- PULSE: result_o=1 for PULSE_CYC cycles → WAIT.
- WAIT: result_o=0 for SETTLE_CYC cycles → SAMPLE.
- SAMPLE (one cycle):
  - tally[i] ← disp_i and total ← total + disp_i.
  - Winner update:
    - disp_i > winner_cnt → winner=i, winner_cnt=disp_i, tie=0.
    - disp_i == winner_cnt and i ≠ 0 → tie=1.
    - i=0 always loads winner=0, winner_cnt=disp_i, tie=0.
  - If i == NUM_CAND-1 → DONE, else i+1 → PULSE.
- DONE: busy=0, done=1. start → CLOSE, with done dropping on the acceptance edge.
- start while busy is ignored; no queueing.
- The n-th result_o pulse after close_o selects candidate n-1. disp_i is stable from SETTLE_CYC cycles after result_o falls until the next pulse.
- Ties keep the lowest index. All-zero counts give winner=0, winner_cnt=0, tie=1.
- total is wide enough for NUM_CAND × (2^CNT_W − 1) and never wraps.
- Strobes never overlap: close_o and result_o are never high in the same cycle.
- One read-out with defaults takes 1 + 4 + 16×(2+4+1) = 117 cycles from acceptance to done.
- rd_data is readable in any state. During a read-out, not-yet-sampled entries read 0.

Optional Feature:
- Macro: VOTE_READER_CHECK_EN.
- Enabled:
  - After the last candidate, one extra PULSE/WAIT/SAMPLE step reads the machine's total display.
  - That value is compared with the lower CNT_W bits of total.
  - Added output err_mismatch (1 bit, reset 0) is set on inequality and cleared on the next accepted start.
  - Read-out length grows by PULSE_CYC+SETTLE_CYC+1 cycles.
- Disabled: no extra step, no err_mismatch port; timing exactly as above.

Test Plan:
- Reset then start; model returns counts 0..15 as 3,0,…,0 → done after 117 cycles, winner=0, winner_cnt=3, tie=0, total=3, rd_idx=0 gives rd_data=3.
- Counts cand1=5, cand5=5, cand9=2, others 0 → winner=1, winner_cnt=5, tie=1, total=12.
- All counts 4095 → winner=0, tie=1, total=65520, no wrap.
- Assert start repeatedly while busy → a single close_o pulse, exactly 16 result_o pulses, done once.
- rst_n low at cycle 50 of a read-out → next edge: busy=0, result_o=0, rd_data=0 for all idx; a new start performs a full read-out.
- With VOTE_READER_CHECK_EN, counts sum 20 and model total 21 → err_mismatch=1; with model total 20 → err_mismatch=0, done after 124 cycles.
